// File: rtl/led_pwm_driver_if.sv
// rtl/led_pwm_driver_if.sv - duty request handshake bundle for led_pwm_driver
// Ports (signals):
//   duty_in    requested duty, on-steps per period
//   duty_valid duty_in valid
//   duty_ready driver can accept a new duty
//   fade_en    1 = ramp to the new duty, 0 = step to it (sampled at period boundaries)
// Modports: master (requester side), slave (driver side).

interface led_pwm_driver_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] duty_in;
   logic             duty_valid;
   logic             duty_ready;
   logic             fade_en;

   modport master (
      output duty_in,
      output duty_valid,
      output fade_en,
      input  duty_ready
   );

   modport slave (
      input  duty_in,
      input  duty_valid,
      input  fade_en,
      output duty_ready
   );
endinterface

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - single-channel LED PWM generator with boundary-aligned duty updates
// Ports:
//   sys_clk      system clock, every register on its rising edge
//   resetn       asynchronous active-low reset
//   pwm_clk      sys_clk-derived divided clock, rising edge = one PWM step
//   duty_if      slave side of the duty request handshake
//   led          registered PWM output
//   duty_active  duty currently applied
//   period_done  one-cycle pulse after each period wrap

module led_pwm_driver #(
   parameter int WIDTH     = 8,
   parameter int FADE_STEP = 1
) (
   input  logic             sys_clk,
   input  logic             resetn,
   input  logic             pwm_clk,
   led_pwm_driver_if.slave  duty_if,
   output logic             led,
   output logic [WIDTH-1:0] duty_active,
   output logic             period_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_FADING
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(FADE_STEP);

   state_t           state_q,       state_d;
   logic [WIDTH-1:0] cnt_q,         cnt_d;
   logic             pwm_clk_dly_q, pwm_clk_dly_d;
   logic [WIDTH-1:0] duty_active_q, duty_active_d;
   logic [WIDTH-1:0] target_q,      target_d;
   logic             led_q,         led_d;
   logic             period_done_q, period_done_d;
   logic             duty_ready_q,  duty_ready_d;

   logic             tick;
   logic             boundary;
   logic             transfer;
   logic [WIDTH-1:0] cnt_next;

   // pwm_clk is derived from sys_clk, so a plain edge detect is enough.
   assign tick     = pwm_clk & ~pwm_clk_dly_q;
   assign boundary = tick & (cnt_q == CNT_MAX);
   assign cnt_next = cnt_q + CNT_ONE;
   assign transfer = duty_ready_q & duty_if.duty_valid;

   // One fade step toward target. The extra bit catches the carry/borrow so
   // the step clamps at target instead of wrapping past it.
   logic [WIDTH:0]   fade_up;
   logic [WIDTH:0]   fade_dn;
   logic [WIDTH:0]   target_ext;
   logic [WIDTH-1:0] fade_val;

   always_comb begin
      target_ext = {1'b0, target_q};
      fade_up    = {1'b0, duty_active_q} + STEP_W;
      fade_dn    = {1'b0, duty_active_q} - STEP_W;
      fade_val   = target_q;
      if (target_q > duty_active_q) begin
         if (fade_up < target_ext) begin
            fade_val = fade_up[WIDTH-1:0];
         end
      end else begin
         if (!fade_dn[WIDTH] && (fade_dn > target_ext)) begin
            fade_val = fade_dn[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pwm_clk_dly_d = pwm_clk;
      duty_active_d = duty_active_q;
      target_d      = target_q;
      led_d         = led_q;
      period_done_d = boundary;

      case (state_q)
         ST_IDLE: begin
            // A boundary in IDLE is ignored, even if a transfer lands on it.
            if (transfer) begin
               target_d = duty_if.duty_in;
               state_d  = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (boundary) begin
               if (!duty_if.fade_en) begin
                  duty_active_d = target_q;
                  state_d       = ST_IDLE;
               end else if (target_q == duty_active_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FADING;
               end
            end
         end
         ST_FADING: begin
            if (boundary) begin
               if (!duty_if.fade_en) begin
                  duty_active_d = target_q;
                  state_d       = ST_IDLE;
               end else begin
                  duty_active_d = fade_val;
                  if (fade_val == target_q) begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Compare against the duty for the period being entered, so the first
      // step after a boundary already uses the new value.
      if (tick) begin
         cnt_d = cnt_next;
         led_d = (cnt_next < duty_active_d);
      end

      duty_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         pwm_clk_dly_q <= 1'b0;
         duty_active_q <= '0;
         target_q      <= '0;
         led_q         <= 1'b0;
         period_done_q <= 1'b0;
         duty_ready_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pwm_clk_dly_q <= pwm_clk_dly_d;
         duty_active_q <= duty_active_d;
         target_q      <= target_d;
         led_q         <= led_d;
         period_done_q <= period_done_d;
         duty_ready_q  <= duty_ready_d;
      end
   end

   assign led                = led_q;
   assign duty_active        = duty_active_q;
   assign period_done        = period_done_q;
   assign duty_if.duty_ready = duty_ready_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - self-checking bench for led_pwm_driver

module tb_led_pwm_driver;

   localparam int W    = 8;
   localparam int STEP = 16;
   localparam int PER  = 256;

   logic         sys_clk = 1'b0;
   logic         resetn  = 1'b0;
   logic         pwm_clk = 1'b0;
   bit           pwm_run = 1'b1;
   logic         led;
   logic [W-1:0] duty_active;
   logic         period_done;

   int n_cmp = 0;
   int n_bad = 0;

   led_pwm_driver_if #(.WIDTH(W)) duty_if ();

   led_pwm_driver #(.WIDTH(W), .FADE_STEP(STEP)) dut (
      .sys_clk     (sys_clk),
      .resetn      (resetn),
      .pwm_clk     (pwm_clk),
      .duty_if     (duty_if),
      .led         (led),
      .duty_active (duty_active),
      .period_done (period_done)
   );

   always #5 sys_clk = ~sys_clk;

   // pwm_clk toggles every sys_clk cycle while running: one step per two cycles.
   always @(posedge sys_clk) begin
      #1;
      if (pwm_run) pwm_clk = ~pwm_clk;
   end

   // Reference model: step index within the period, duty per period and a
   // single outstanding request that is resolved at period ends.
   int m_step = 0;
   int m_duty = 0;
   int m_target = 0;
   bit m_busy = 0;
   bit m_fading = 0;
   bit m_prev_pwm = 0;
   bit m_led = 0;
   bit m_pd = 0;

   always @(posedge sys_clk or negedge resetn) begin
      bit take;
      bit stepped;
      int diff;
      if (!resetn) begin
         m_step = 0; m_duty = 0; m_target = 0; m_busy = 0;
         m_fading = 0; m_prev_pwm = 0; m_led = 0; m_pd = 0;
      end else begin
         take = !m_busy && (duty_if.duty_valid === 1'b1);
         stepped = (pwm_clk === 1'b1) && !m_prev_pwm;
         m_prev_pwm = (pwm_clk === 1'b1);
         m_pd = 0;
         if (stepped) begin
            m_step = (m_step + 1) % PER;
            if (m_step == 0) begin
               m_pd = 1;
               if (m_busy) begin
                  if (duty_if.fade_en !== 1'b1) begin
                     m_duty = m_target;
                     m_busy = 0;
                  end else if (!m_fading) begin
                     if (m_target == m_duty) m_busy = 0;
                     else m_fading = 1;
                  end else begin
                     diff = m_target - m_duty;
                     if (diff > STEP) diff = STEP;
                     if (diff < -STEP) diff = -STEP;
                     m_duty = m_duty + diff;
                     if (m_duty == m_target) m_busy = 0;
                  end
               end
               if (!m_busy) m_fading = 0;
            end
            m_led = (m_step < m_duty);
         end
         if (take) begin
            m_target = int'(duty_if.duty_in);
            m_busy = 1;
            m_fading = 0;
         end
      end
   end

   // Wait (bounded) for the next period_done pulse; leaves the caller at that negedge.
   task automatic wait_pd(input string tag);
      int n;
      n = 0;
      @(negedge sys_clk);
      while (period_done !== 1'b1 && n < 1200) begin
         @(negedge sys_clk);
         n++;
      end
      if (period_done !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: no period_done within %0d cycles", tag, n);
      end
   endtask

   // Drive one transfer; waits (bounded) for duty_ready first.
   task automatic send_duty(input int d, input bit fade);
      int n;
      n = 0;
      while (duty_if.duty_ready !== 1'b1 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      if (duty_if.duty_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: duty_ready stuck at %b", duty_if.duty_ready);
      end
      duty_if.duty_in    = W'(d);
      duty_if.fade_en    = fade;
      duty_if.duty_valid = 1'b1;
      @(posedge sys_clk);
      #1 duty_if.duty_valid = 1'b0;
   endtask

   // Count led-high samples over one full period (512 negedges) from the current negedge.
   task automatic count_led_period(output int hi);
      hi = 0;
      for (int i = 0; i < 2 * PER; i++) begin
         if (led === 1'b1) hi++;
         @(negedge sys_clk);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led: got %b want 0", led); end
      n_cmp++; if (duty_active !== 8'd0) begin n_bad++; $display("FAIL reset_duty: got %0d want 0", duty_active); end
      n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL reset_pd: got %b want 0", period_done); end
      n_cmp++; if (duty_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", duty_if.duty_ready); end
      resetn = 1'b1;
   endtask

   task automatic test_zero_duty();
      int hi, gap;
      wait_pd("zero");
      hi = (led === 1'b1) ? 1 : 0;
      @(negedge sys_clk);
      gap = 1;
      n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL zero_pd_width: got %b want 0 one cycle after pulse", period_done); end
      while (period_done !== 1'b1 && gap < 1200) begin
         if (led === 1'b1) hi++;
         @(negedge sys_clk);
         gap++;
      end
      n_cmp++; if (gap != 2 * PER) begin n_bad++; $display("FAIL zero_pd_spacing: got %0d cycles want %0d", gap, 2 * PER); end
      n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL zero_led: got %0d high samples want 0", hi); end
   endtask

   task automatic test_step_64();
      int hi;
      send_duty(64, 1'b0);
      @(negedge sys_clk);
      n_cmp++; if (duty_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL s64_ready_fall: got %b want 0", duty_if.duty_ready); end
      wait_pd("s64");
      n_cmp++; if (duty_active !== 8'd64) begin n_bad++; $display("FAIL s64_duty: got %0d want 64", duty_active); end
      n_cmp++; if (duty_if.duty_ready !== 1'b1) begin n_bad++; $display("FAIL s64_ready_rise: got %b want 1", duty_if.duty_ready); end
      count_led_period(hi);
      n_cmp++; if (hi != 2 * 64) begin n_bad++; $display("FAIL s64_on_steps: got %0d want %0d", hi / 2, 64); end
   endtask

   task automatic test_full_and_off();
      int hi;
      send_duty(255, 1'b0);
      wait_pd("full");
      n_cmp++; if (duty_active !== 8'd255) begin n_bad++; $display("FAIL full_duty: got %0d want 255", duty_active); end
      count_led_period(hi);
      n_cmp++; if (hi != 2 * 255) begin n_bad++; $display("FAIL full_on_steps: got %0d want 255", hi / 2); end
      send_duty(0, 1'b0);
      wait_pd("off");
      n_cmp++; if (duty_active !== 8'd0) begin n_bad++; $display("FAIL off_duty: got %0d want 0", duty_active); end
      count_led_period(hi);
      n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL off_on_steps: got %0d want 0", hi / 2); end
   endtask

   task automatic test_fade();
      int up_seq[3];
      int dn_seq[3];
      up_seq = '{16, 32, 40};
      dn_seq = '{24, 8, 0};
      send_duty(40, 1'b1);
      wait_pd("fade_up_start");
      n_cmp++; if (duty_active !== 8'd0 || duty_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL fade_up_start: got duty %0d ready %b want 0 / 0", duty_active, duty_if.duty_ready); end
      for (int k = 0; k < 3; k++) begin
         wait_pd("fade_up");
         n_cmp++; if (duty_active !== 8'(up_seq[k])) begin n_bad++; $display("FAIL fade_up_duty%0d: got %0d want %0d", k, duty_active, up_seq[k]); end
         n_cmp++; if (duty_if.duty_ready !== (k == 2)) begin n_bad++; $display("FAIL fade_up_ready%0d: got %b want %b", k, duty_if.duty_ready, k == 2); end
      end
      send_duty(0, 1'b1);
      wait_pd("fade_dn_start");
      n_cmp++; if (duty_active !== 8'd40) begin n_bad++; $display("FAIL fade_dn_start: got %0d want 40", duty_active); end
      for (int k = 0; k < 3; k++) begin
         wait_pd("fade_dn");
         n_cmp++; if (duty_active !== 8'(dn_seq[k])) begin n_bad++; $display("FAIL fade_dn_duty%0d: got %0d want %0d", k, duty_active, dn_seq[k]); end
         n_cmp++; if (duty_if.duty_ready !== (k == 2)) begin n_bad++; $display("FAIL fade_dn_ready%0d: got %b want %b", k, duty_if.duty_ready, k == 2); end
      end
      duty_if.fade_en = 1'b0;
   endtask

   task automatic test_handshake();
      int ready_hi;
      wait_pd("hs_sync");
      send_duty(100, 1'b0);
      ready_hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge sys_clk);
         if (duty_if.duty_ready === 1'b1) ready_hi++;
         duty_if.duty_in    = W'($urandom_range(0, 255));
         duty_if.duty_valid = 1'b1;
      end
      @(negedge sys_clk);
      duty_if.duty_valid = 1'b0;
      n_cmp++; if (ready_hi != 0) begin n_bad++; $display("FAIL hs_ready_low: got %0d ready cycles want 0", ready_hi); end
      wait_pd("hs_apply");
      n_cmp++; if (duty_active !== 8'd100) begin n_bad++; $display("FAIL hs_first_only: got %0d want 100", duty_active); end
      // Land a transfer exactly on the next boundary tick (512 cycles later).
      repeat (2 * PER - 1) @(posedge sys_clk);
      #1;
      duty_if.duty_in    = 8'd200;
      duty_if.duty_valid = 1'b1;
      @(posedge sys_clk);
      #1 duty_if.duty_valid = 1'b0;
      @(negedge sys_clk);
      n_cmp++; if (period_done !== 1'b1) begin n_bad++; $display("FAIL hs_on_boundary: got pd %b want 1", period_done); end
      n_cmp++; if (duty_active !== 8'd100 || duty_if.duty_ready !== 1'b0) begin n_bad++; $display("FAIL hs_not_yet: got duty %0d ready %b want 100 / 0", duty_active, duty_if.duty_ready); end
      wait_pd("hs_late");
      n_cmp++; if (duty_active !== 8'd200) begin n_bad++; $display("FAIL hs_late_apply: got %0d want 200", duty_active); end
   endtask

   task automatic test_stall();
      logic         led0;
      logic [W-1:0] duty0;
      int           moved;
      send_duty(50, 1'b0);
      repeat (5) @(negedge sys_clk);
      pwm_run = 1'b0;
      repeat (2) @(negedge sys_clk);
      led0  = led;
      duty0 = duty_active;
      moved = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge sys_clk);
         if (led !== led0 || duty_active !== duty0 || duty_if.duty_ready !== 1'b0 || period_done !== 1'b0) moved++;
      end
      n_cmp++; if (moved != 0) begin n_bad++; $display("FAIL stall_hold: got %0d changed cycles want 0", moved); end
      pwm_run = 1'b1;
      wait_pd("stall");
      n_cmp++; if (duty_active !== 8'd50) begin n_bad++; $display("FAIL stall_apply: got %0d want 50", duty_active); end
   endtask

   task automatic test_async_reset();
      int bad;
      send_duty(0, 1'b0);
      wait_pd("ar_zero");
      send_duty(200, 1'b1);
      wait_pd("ar_f0");
      wait_pd("ar_f1");
      wait_pd("ar_f2");
      n_cmp++; if (duty_active !== 8'd32) begin n_bad++; $display("FAIL ar_mid_fade: got %0d want 32", duty_active); end
      repeat (20) @(negedge sys_clk);
      n_cmp++; if (led !== 1'b1) begin n_bad++; $display("FAIL ar_led_on: got %b want 1", led); end
      #2 resetn = 1'b0;
      #1;
      n_cmp++; if (led !== 1'b0 || duty_active !== 8'd0 || period_done !== 1'b0 || duty_if.duty_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ar_async: got led %b duty %0d pd %b ready %b want 0 0 0 1", led, duty_active, period_done, duty_if.duty_ready);
      end
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      resetn = 1'b1;
      bad = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge sys_clk);
         if (duty_active !== 8'd0 || led !== 1'b0 || duty_if.duty_ready !== 1'b1) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL ar_after_release: got %0d bad cycles want 0", bad); end
      duty_if.fade_en = 1'b0;
   endtask

   task automatic test_random();
      int stall;
      int sel;
      stall = 0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge sys_clk);
         n_cmp++; if (led !== m_led) begin n_bad++; $display("FAIL rnd_led @%0d: got %b want %b", i, led, m_led); end
         n_cmp++; if (duty_active !== 8'(m_duty)) begin n_bad++; $display("FAIL rnd_duty @%0d: got %0d want %0d", i, duty_active, m_duty); end
         n_cmp++; if (period_done !== m_pd) begin n_bad++; $display("FAIL rnd_pd @%0d: got %b want %b", i, period_done, m_pd); end
         n_cmp++; if (duty_if.duty_ready !== !m_busy) begin n_bad++; $display("FAIL rnd_ready @%0d: got %b want %b", i, duty_if.duty_ready, !m_busy); end
         sel = $urandom_range(0, 3);
         duty_if.duty_in    = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : W'($urandom_range(0, 255));
         duty_if.duty_valid = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) duty_if.fade_en = ~duty_if.fade_en;
         if (stall > 0) begin
            stall--;
            pwm_run = (stall == 0);
         end else if ($urandom_range(0, 299) == 0) begin
            stall   = $urandom_range(1, 60);
            pwm_run = 1'b0;
         end
         if (i == 6000) resetn = 1'b0;
         if (i == 6003) resetn = 1'b1;
      end
      pwm_run = 1'b1;
      duty_if.duty_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      duty_if.duty_in    = '0;
      duty_if.duty_valid = 1'b0;
      duty_if.fade_en    = 1'b0;
      test_reset();
      test_zero_duty();
      test_step_64();
      test_full_and_off();
      test_fade();
      test_handshake();
      test_stall();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
